// File: rtl/inta_sequencer.sv
// ---------------------------------------------------------------------------
// inta_sequencer
//
// Interrupt controller core between the IRR/IMR registers and the data bus
// buffer. It picks the highest-priority pending request (IR0 highest) that is
// not masked and not blocked by a higher-or-equal level already in service,
// raises INT, and runs the two-pulse 8086 INTA handshake:
//   1st INTA fall : latch winner, set ISR bit, pulse clear_IRR for one cycle
//   2nd INTA fall : drive {vector_Base, idx} on data_Out with data_Out_En
//   INTA rise     : release the bus (optionally auto-EOI) and return to IDLE
// EOI commands (specific / non-specific) clear ISR bits at any time.
//
// Parameters:
//   AEOI           - 1: clear the ISR bit automatically at the end of the
//                    second INTA pulse
// Ports:
//   clk            - system clock
//   rst_n          - asynchronous active-low reset
//   IRR_Output     - pending requests, bit i = IRi
//   interrupt_Mask - IMR, 1 = IRi masked
//   vector_Base    - vector bits T7..T3
//   inta_n         - CPU interrupt acknowledge (active low, synchronous)
//   eoi_Valid      - one-cycle EOI command strobe
//   eoi_Specific   - 1 = specific EOI, 0 = non-specific EOI
//   eoi_Level      - IR level targeted by a specific EOI
//   INT            - interrupt request to the CPU
//   clear_IRR      - one-hot, one-cycle clear of the acknowledged IRR bit
//   ISR_Output     - in-service register
//   data_Out       - vector byte
//   data_Out_En    - data bus drive enable
// ---------------------------------------------------------------------------
module inta_sequencer #(
    parameter bit AEOI = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] IRR_Output,
    input  logic [7:0] interrupt_Mask,
    input  logic [4:0] vector_Base,
    input  logic       inta_n,
    input  logic       eoi_Valid,
    input  logic       eoi_Specific,
    input  logic [2:0] eoi_Level,
    output logic       INT,
    output logic [7:0] clear_IRR,
    output logic [7:0] ISR_Output,
    output logic [7:0] data_Out,
    output logic       data_Out_En
);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ACK1,
        ACK2
    } state_t;

    state_t     state_q, state_d;
    logic       int_q, int_d;
    logic [7:0] clear_irr_q, clear_irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_out_en_q, data_out_en_d;
    logic [2:0] idx_q, idx_d;
    logic       spurious_q, spurious_d;
    logic       inta_prev_q;

    logic       fall, rise;
    logic [7:0] cand, qual;
    logic       blocked;
    logic       win_valid;
    logic [2:0] win_idx;
    logic [7:0] eoi_clear, aeoi_clear, set_mask;

    assign fall = inta_prev_q & ~inta_n;
    assign rise = ~inta_prev_q & inta_n;

    // Priority resolution: a candidate only qualifies while no ISR bit at
    // its own or a higher-priority (lower) index is set.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        cand      = IRR_Output & ~interrupt_Mask;
        qual      = 8'h00;
        blocked   = 1'b0;
        win_valid = 1'b0;
        win_idx   = 3'd7;
        for (int i = 0; i < 8; i++) begin
            blocked = blocked | isr_q[i];
            qual[i] = cand[i] & ~blocked;
        end
        for (int i = 7; i >= 0; i--) begin
            if (qual[i]) begin
                win_valid = 1'b1;
                win_idx   = 3'(i);
            end
        end
    end

    // EOI target: lowest set ISR bit (isolated with x & -x) or the named level.
    always_comb begin
        eoi_clear = 8'h00;
        if (eoi_Valid) begin
            if (eoi_Specific) eoi_clear = 8'b1 << eoi_Level;
            else              eoi_clear = isr_q & (~isr_q + 8'd1);
        end
    end

    always_comb begin
        state_d       = state_q;
        int_d         = int_q;
        clear_irr_d   = 8'h00;      // pulse output: only ever high for one cycle
        data_out_d    = data_out_q;
        data_out_en_d = data_out_en_q;
        idx_d         = idx_q;
        spurious_d    = spurious_q;
        set_mask      = 8'h00;
        aeoi_clear    = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    int_d   = 1'b1;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                // INT stays asserted here even if the request goes away; the
                // CPU is already committed to acknowledging it.
                if (fall) begin
                    int_d      = 1'b0;
                    idx_d      = win_idx;
                    spurious_d = ~win_valid;
                    if (win_valid) begin
                        set_mask    = 8'b1 << win_idx;
                        clear_irr_d = 8'b1 << win_idx;
                    end
                    state_d = ACK1;
                end
            end
            ACK1: begin
                if (fall) begin
                    data_out_d    = {vector_Base, idx_q};
                    data_out_en_d = 1'b1;
                    state_d       = ACK2;
                end
            end
            ACK2: begin
                if (rise) begin
                    data_out_d    = 8'h00;
                    data_out_en_d = 1'b0;
                    if (AEOI && !spurious_q) aeoi_clear = 8'b1 << idx_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A set in the same cycle as a clear of the same bit wins.
        isr_d = (isr_q & ~(eoi_clear | aeoi_clear)) | set_mask;
    end

    // NOTE: the ISR and all handshake state are reset so an interrupted sequence is fully abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            int_q         <= 1'b0;
            clear_irr_q   <= 8'h00;
            isr_q         <= 8'h00;
            data_out_q    <= 8'h00;
            data_out_en_q <= 1'b0;
            idx_q         <= 3'd0;
            spurious_q    <= 1'b0;
            inta_prev_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            int_q         <= int_d;
            clear_irr_q   <= clear_irr_d;
            isr_q         <= isr_d;
            data_out_q    <= data_out_d;
            data_out_en_q <= data_out_en_d;
            idx_q         <= idx_d;
            spurious_q    <= spurious_d;
            inta_prev_q   <= inta_n;
        end
    end

    assign INT         = int_q;
    assign clear_IRR   = clear_irr_q;
    assign ISR_Output  = isr_q;
    assign data_Out    = data_out_q;
    assign data_Out_En = data_out_en_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// ---------------------------------------------------------------------------
// tb_inta_sequencer
//
// Self-checking bench for inta_sequencer. Two instances share the stimulus:
// dut (AEOI=0) and dut_a (AEOI=1). Expected clear_IRR pulses and vector bytes
// of dut are queued when the handshake is driven and compared by a monitor
// when dut produces them; scenario tasks check the remaining state inline.
// ---------------------------------------------------------------------------
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irr, imr;
    logic [4:0] vbase;
    logic       inta_n;
    logic       eoi_v, eoi_s;
    logic [2:0] eoi_l;

    logic       int_o, den;
    logic [7:0] clr, isr, dout;
    logic       a_int, a_den;
    logic [7:0] a_clr, a_isr, a_dout;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_clr_q[$];
    logic [7:0] exp_vec_q[$];
    logic [7:0] mon_e;
    logic       en_prev = 1'b0;

    always #5 clk = ~clk;

    inta_sequencer #(.AEOI(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .IRR_Output(irr), .interrupt_Mask(imr),
        .vector_Base(vbase), .inta_n(inta_n), .eoi_Valid(eoi_v),
        .eoi_Specific(eoi_s), .eoi_Level(eoi_l), .INT(int_o), .clear_IRR(clr),
        .ISR_Output(isr), .data_Out(dout), .data_Out_En(den)
    );

    inta_sequencer #(.AEOI(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .IRR_Output(irr), .interrupt_Mask(imr),
        .vector_Base(vbase), .inta_n(inta_n), .eoi_Valid(eoi_v),
        .eoi_Specific(eoi_s), .eoi_Level(eoi_l), .INT(a_int), .clear_IRR(a_clr),
        .ISR_Output(a_isr), .data_Out(a_dout), .data_Out_En(a_den)
    );

    // Scoreboard monitor: every clear_IRR pulse and every data_Out_En rise
    // of dut must match the next queued expectation.
    always @(negedge clk) begin
        if (clr !== 8'h00) begin
            total++;
            if (exp_clr_q.size() == 0) begin
                bad++; $display("FAIL clear_irr_unexpected got=%h want=none", clr);
            end else begin
                mon_e = exp_clr_q.pop_front();
                if (clr !== mon_e) begin bad++; $display("FAIL clear_irr got=%h want=%h", clr, mon_e); end
            end
        end
        if (den === 1'b1 && en_prev !== 1'b1) begin
            total++;
            if (exp_vec_q.size() == 0) begin
                bad++; $display("FAIL vector_unexpected got=%h want=none", dout);
            end else begin
                mon_e = exp_vec_q.pop_front();
                if (dout !== mon_e) begin bad++; $display("FAIL vector got=%h want=%h", dout, mon_e); end
            end
        end
        en_prev = den;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; inta_n = 1'b1; irr = 8'h00; imr = 8'h00;
        eoi_v = 1'b0; eoi_s = 1'b0; eoi_l = 3'd0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Full two-pulse handshake on dut with inline checks of the pulse shape.
    task automatic do_handshake(input logic [7:0] want_clr, input logic spur, input logic [7:0] want_vec);
        if (!spur) exp_clr_q.push_back(want_clr);
        inta_n = 1'b0; tick();
        total++; if (int_o !== 1'b0) begin bad++; $display("FAIL hs_int_drop got=%b want=0", int_o); end
        total++; if (clr !== (spur ? 8'h00 : want_clr)) begin bad++; $display("FAIL hs_clr got=%h want=%h", clr, spur ? 8'h00 : want_clr); end
        inta_n = 1'b1; tick();
        total++; if (clr !== 8'h00) begin bad++; $display("FAIL hs_clr_one_cycle got=%h want=00", clr); end
        total++; if (den !== 1'b0) begin bad++; $display("FAIL hs_en_early got=%b want=0", den); end
        exp_vec_q.push_back(want_vec);
        inta_n = 1'b0; tick();
        total++; if (den !== 1'b1 || dout !== want_vec) begin bad++; $display("FAIL hs_vec en=%b data=%h want en=1 data=%h", den, dout, want_vec); end
        tick();
        total++; if (den !== 1'b1) begin bad++; $display("FAIL hs_en_hold got=%b want=1", den); end
        inta_n = 1'b1; tick();
        total++; if (den !== 1'b0 || dout !== 8'h00) begin bad++; $display("FAIL hs_release en=%b data=%h want en=0 data=00", den, dout); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inta_n = 1'b1; irr = 8'h00; imr = 8'h00; vbase = 5'b01000;
        eoi_v = 1'b0; eoi_s = 1'b0; eoi_l = 3'd0;
        #2;
        total++; if ({int_o, clr, isr, dout, den} !== 26'd0) begin bad++; $display("FAIL reset_dut got=%h want=0", {int_o, clr, isr, dout, den}); end
        total++; if ({a_int, a_clr, a_isr, a_dout, a_den} !== 26'd0) begin bad++; $display("FAIL reset_dut_a got=%h want=0", {a_int, a_clr, a_isr, a_dout, a_den}); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        irr = 8'h12; tick();
        total++; if (int_o !== 1'b1) begin bad++; $display("FAIL basic_int got=%b want=1", int_o); end
        do_handshake(8'h02, 1'b0, 8'h41);
        total++; if (isr !== 8'h02) begin bad++; $display("FAIL basic_isr got=%h want=02", isr); end
    endtask

    task automatic test_nonspecific_eoi();
        irr = 8'h10; tick(); tick();
        total++; if (int_o !== 1'b0) begin bad++; $display("FAIL ns_blocked got=%b want=0", int_o); end
        eoi_v = 1'b1; eoi_s = 1'b0; tick(); eoi_v = 1'b0;
        total++; if (isr !== 8'h00) begin bad++; $display("FAIL ns_eoi_isr got=%h want=00", isr); end
        tick();
        total++; if (int_o !== 1'b1) begin bad++; $display("FAIL ns_int got=%b want=1", int_o); end
        do_handshake(8'h10, 1'b0, 8'h44);
        total++; if (isr !== 8'h10) begin bad++; $display("FAIL ns_isr got=%h want=10", isr); end
    endtask

    task automatic test_mask_specific_eoi();
        do_reset();
        irr = 8'h80; imr = 8'h80; tick(); tick(); tick();
        total++; if (int_o !== 1'b0) begin bad++; $display("FAIL mask_int got=%b want=0", int_o); end
        imr = 8'h00; tick();
        total++; if (int_o !== 1'b1) begin bad++; $display("FAIL unmask_int got=%b want=1", int_o); end
        do_handshake(8'h80, 1'b0, 8'h47);
        total++; if (isr !== 8'h80) begin bad++; $display("FAIL mask_isr got=%h want=80", isr); end
        irr = 8'h00;
        eoi_v = 1'b1; eoi_s = 1'b1; eoi_l = 3'd7; tick(); eoi_v = 1'b0;
        total++; if (isr !== 8'h00) begin bad++; $display("FAIL sp_eoi_isr got=%h want=00", isr); end
    endtask

    task automatic test_spurious();
        do_reset();
        irr = 8'h08; tick();
        total++; if (int_o !== 1'b1) begin bad++; $display("FAIL spur_int got=%b want=1", int_o); end
        irr = 8'h00; tick();
        total++; if (int_o !== 1'b1) begin bad++; $display("FAIL spur_int_held got=%b want=1", int_o); end
        do_handshake(8'h00, 1'b1, 8'h47);
        total++; if (isr !== 8'h00) begin bad++; $display("FAIL spur_isr got=%h want=00", isr); end
    endtask

    task automatic test_aeoi();
        do_reset();
        irr = 8'h01; tick();
        total++; if (a_int !== 1'b1) begin bad++; $display("FAIL aeoi_int got=%b want=1", a_int); end
        do_handshake(8'h01, 1'b0, 8'h40);
        total++; if (a_isr !== 8'h00) begin bad++; $display("FAIL aeoi_isr got=%h want=00", a_isr); end
        total++; if (isr !== 8'h01) begin bad++; $display("FAIL no_aeoi_isr got=%h want=01", isr); end
        total++; if (a_int !== 1'b0) begin bad++; $display("FAIL aeoi_idle_gap got=%b want=0", a_int); end
        tick();
        total++; if (a_int !== 1'b1) begin bad++; $display("FAIL aeoi_reraise got=%b want=1", a_int); end
        total++; if (int_o !== 1'b0) begin bad++; $display("FAIL no_aeoi_blocked got=%b want=0", int_o); end
    endtask

    task automatic test_reset_mid_handshake();
        do_reset();
        irr = 8'h04; tick();
        exp_clr_q.push_back(8'h04);
        inta_n = 1'b0; tick();
        total++; if (isr !== 8'h04) begin bad++; $display("FAIL mid_isr got=%h want=04", isr); end
        inta_n = 1'b1; tick();
        irr = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({int_o, clr, isr, dout, den} !== 26'd0) begin bad++; $display("FAIL mid_reset got=%h want=0", {int_o, clr, isr, dout, den}); end
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        total++; if (int_o !== 1'b0 || clr !== 8'h00) begin bad++; $display("FAIL post_reset int=%b clr=%h want int=0 clr=00", int_o, clr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nonspecific_eoi();
        test_mask_specific_eoi();
        test_spurious();
        test_aeoi();
        test_reset_mid_handshake();
        tick();
        total++; if (exp_clr_q.size() != 0 || exp_vec_q.size() != 0) begin bad++; $display("FAIL scoreboard_left clr=%0d vec=%0d want 0", exp_clr_q.size(), exp_vec_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Consumer side of the IRR: reads pending requests (IRR_Output), resolves priority against the mask and the in-service register, and raises INT.
- Runs the two-pulse 8086-style INTA handshake.
- On the first INTA pulse it sets the ISR bit and pulses clear_IRR back to the IRR. On the second pulse it drives the interrupt vector onto the data bus.
- Handles EOI commands; sits between the IRR/IMR registers and the CPU-facing data bus buffer.

Parameters:
- AEOI, 0: when 1, the ISR bit is cleared automatically at the end of the second INTA pulse.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- IRR_Output  in  8  pending requests from IRR; bit i = IRi
- interrupt_Mask  in  8  IMR; 1 = IRi masked
- vector_Base  in  5  T7..T3 from ICW2
- inta_n  in  1  CPU interrupt acknowledge, active low; already synchronous to clk
- eoi_Valid  in  1  one-cycle EOI command strobe
- eoi_Specific  in  1  1 = specific EOI, 0 = non-specific EOI
- eoi_Level  in  3  IR level for specific EOI
- INT  out  1  interrupt request to CPU
- clear_IRR  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit
- ISR_Output  out  8  in-service register
- data_Out  out  8  vector byte
- data_Out_En  out  1  data bus drive enable

Behaviour:

Reset:
- Asynchronous, on rst_n low. INT=0, clear_IRR=0, ISR_Output=0, data_Out=0, data_Out_En=0, state=IDLE, inta_prev=1.
- Reset mid-handshake abandons the sequence. No clear_IRR pulse is emitted afterwards.

Priority:
- Fixed priority, IR0 highest.
- cand = IRR_Output & ~interrupt_Mask.
- A candidate bit i qualifies only if i < lowest set ISR index. With ISR=0, all candidates qualify.
- Winner = lowest qualifying index.

Edges:
- fall = inta_prev & ~inta_n.
- rise = ~inta_prev & inta_n.
- inta_prev is registered every cycle.

State machine (all outputs registered):
- IDLE: if a qualifying request exists at edge k, INT=1 from edge k, go PENDING.
- PENDING: INT held high even if the request is withdrawn. On fall:
  - Latch the winner index to idx, set ISR[idx], and drive clear_IRR = 1<<idx for exactly one cycle.
  - INT=0; go ACK1.
  - If no qualifying request remains at fall (spurious): idx=7, no ISR set, clear_IRR=0.
- ACK1: on fall: data_Out={vector_Base,idx}, data_Out_En=1, go ACK2.
- ACK2: on rise:
  - data_Out_En=0, data_Out=0.
  - If AEOI=1 and not spurious, clear ISR[idx].
  - Go IDLE.
  - A new qualifying request can raise INT no earlier than one cycle after IDLE is re-entered.
- A rise in PENDING or ACK1 is ignored.

EOI (when eoi_Valid=1):
- Non-specific EOI clears the lowest-index set ISR bit.
- Specific EOI clears ISR[eoi_Level].
- No effect if the target bit is already 0.

Simultaneous ISR set and EOI clear in one cycle: ISR_next = (ISR & ~eoi_clear) | set_mask. A set wins on the same bit.

clear_IRR is never asserted outside the single cycle following the first-INTA fall.

Test Plan:
1. IRR_Output=8'h12, mask=0, vector_Base=5'b01000 → INT=1. First INTA: clear_IRR=8'h02 for one cycle, ISR=8'h02. Second INTA: data_Out=8'h41, data_Out_En=1 until inta_n rises.
2. After scenario 1 with IRR_Output=8'h10 and ISR=8'h02 → INT stays 0. Non-specific EOI → ISR=0, then INT=1. Handshake yields clear_IRR=8'h10, data_Out=8'h44.
3. IRR_Output=8'h80, mask=8'h80 → INT never asserts. Unmask → INT=1. Full handshake gives data_Out=8'h47 and ISR=8'h80. Specific EOI level 7 → ISR=0.
4. IRR_Output=8'h08, INT=1, then IRR_Output=0 before the first INTA → clear_IRR=0, ISR unchanged, data_Out={base,3'b111}.
5. AEOI=1, IRR_Output=8'h01 → after the second INTA rises, ISR=0 with no EOI issued.
6. rst_n low during ACK1 → all outputs 0 immediately. After release with IRR_Output=0: INT=0, no clear_IRR pulse.
